// File: rtl/render_frame_sequencer_pkg.sv
// Shared constants for the frame sequencer: game-state and direction codes, default geometry.
// Also provides a width helper that stays valid for degenerate counts.
package render_frame_sequencer_pkg;

  localparam logic [2:0] GAME_STATE_PLAYING = 3'd1;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int unsigned TILE_SIZE_PX = 20;
  localparam int unsigned WIDTH_LOG2   = 10;
  localparam int unsigned HEIGHT_LOG2  = 10;

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/render_frame_sequencer_if.sv
// Sprite update port from game logic: ready/valid handshake carrying slot, position and direction.
interface render_frame_sequencer_if #(
  parameter int unsigned X_W = 10,
  parameter int unsigned Y_W = 10
);

  logic           upd_valid;
  logic           upd_ready;
  logic [2:0]     upd_id;
  logic [X_W-1:0] upd_x;
  logic [Y_W-1:0] upd_y;
  logic [1:0]     upd_dir;

  modport master (
    output upd_valid,
    output upd_id,
    output upd_x,
    output upd_y,
    output upd_dir,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_id,
    input  upd_x,
    input  upd_y,
    input  upd_dir,
    output upd_ready
  );

endinterface

// File: rtl/render_frame_sequencer_sprite_line_hit.sv
// Vertical overlap test of one sprite against a scanline.
// The bottom edge is formed one bit wider so sprites near the screen bottom never wrap.
module render_frame_sequencer_sprite_line_hit #(
  parameter int unsigned Y_W       = 10,
  parameter int unsigned TILE_SIZE = 20
) (
  input  logic [Y_W-1:0] i_line_y,
  input  logic [Y_W-1:0] i_spr_y,
  output logic           o_hit
);

  logic [Y_W:0] w_bottom;

  assign w_bottom = {1'b0, i_spr_y} + (Y_W+1)'(TILE_SIZE);
  assign o_hit    = (i_line_y >= i_spr_y) && ({1'b0, i_line_y} < w_bottom);

endmodule

// File: rtl/render_frame_sequencer.sv
// Per-frame sequencer: stages sprite updates, commits them to shadow registers at frame start,
// runs the animation-frame timer and builds a per-scanline sprite overlap mask.
module render_frame_sequencer
  import render_frame_sequencer_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 5,
  parameter int unsigned X_W         = WIDTH_LOG2,
  parameter int unsigned Y_W         = HEIGHT_LOG2,
  parameter int unsigned TILE_SIZE   = TILE_SIZE_PX,
  parameter int unsigned ANIM_DIV    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               i_game_state,
  input  logic                     i_frame_start,
  input  logic                     i_line_start,
  input  logic [Y_W-1:0]           i_line_y,
  render_frame_sequencer_if.slave  upd_if,
  output logic [NUM_SPRITES*X_W-1:0] o_spr_x,
  output logic [NUM_SPRITES*Y_W-1:0] o_spr_y,
  output logic [NUM_SPRITES*2-1:0]   o_spr_dir,
  output logic                     o_anim_frame,
  output logic [NUM_SPRITES-1:0]   o_line_mask,
  output logic                     o_line_mask_valid,
  output logic                     o_overrun
);

  localparam int unsigned IDX_W = cnt_width(NUM_SPRITES);
  localparam int unsigned CNT_W = cnt_width(ANIM_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ANIM_DIV - 1);

  typedef enum logic [1:0] {StIdle, StCommit, StScan} state_e;

  state_e                 r_state, w_state_d;
  logic [IDX_W-1:0]       r_idx, w_idx_d;
  logic [Y_W-1:0]         r_line_y, w_line_y_d;
  logic [NUM_SPRITES-1:0] r_acc, w_acc_d;
  logic [NUM_SPRITES-1:0] r_mask, w_mask_d;
  logic                   r_mask_valid, w_mask_valid_d;
  logic                   r_overrun, w_overrun_d;
  logic [CNT_W-1:0]       r_anim_cnt, w_anim_cnt_d;
  logic                   r_anim_frame, w_anim_frame_d;

  logic [X_W-1:0] r_stg_x   [NUM_SPRITES];
  logic [Y_W-1:0] r_stg_y   [NUM_SPRITES];
  logic [1:0]     r_stg_dir [NUM_SPRITES];
  logic [X_W-1:0] r_shd_x   [NUM_SPRITES];
  logic [Y_W-1:0] r_shd_y   [NUM_SPRITES];
  logic [1:0]     r_shd_dir [NUM_SPRITES];

  logic           w_accept;
  logic           w_commit;
  logic           w_hit;
  logic [Y_W-1:0] w_sy;

  assign upd_if.upd_ready = (r_state != StCommit);
  assign w_accept         = upd_if.upd_valid & upd_if.upd_ready;
  assign w_commit         = (r_state == StCommit);
  assign w_sy             = r_shd_y[r_idx];

  render_frame_sequencer_sprite_line_hit #(
    .Y_W       (Y_W),
    .TILE_SIZE (TILE_SIZE)
  ) u_hit (
    .i_line_y (r_line_y),
    .i_spr_y  (w_sy),
    .o_hit    (w_hit)
  );

  // frame_start outranks everything; line_start only restarts a scan when no frame is starting.
  always_comb begin
    w_state_d      = r_state;
    w_idx_d        = r_idx;
    w_line_y_d     = r_line_y;
    w_acc_d        = r_acc;
    w_mask_d       = r_mask;
    w_mask_valid_d = 1'b0;
    w_overrun_d    = r_overrun;
    unique case (r_state)
      StIdle: begin
        if (i_frame_start) begin
          w_state_d = StCommit;
        end else if (i_line_start) begin
          w_state_d  = StScan;
          w_idx_d    = '0;
          w_line_y_d = i_line_y;
          w_acc_d    = '0;
        end
      end
      StCommit: begin
        w_state_d = i_frame_start ? StCommit : StIdle;
      end
      StScan: begin
        if (i_frame_start) begin
          w_state_d = StCommit;
        end else if (i_line_start) begin
          w_overrun_d = 1'b1;
          w_idx_d     = '0;
          w_line_y_d  = i_line_y;
          w_acc_d     = '0;
        end else begin
          w_acc_d[r_idx] = w_hit;
          if (r_idx == LAST_IDX) begin
            w_mask_d       = w_acc_d;
            w_mask_valid_d = 1'b1;
            w_state_d      = StIdle;
          end else begin
            w_idx_d = r_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_anim_cnt_d   = r_anim_cnt;
    w_anim_frame_d = r_anim_frame;
    if (w_commit && (i_game_state == GAME_STATE_PLAYING)) begin
      if (r_anim_cnt == CNT_MAX) begin
        w_anim_cnt_d   = '0;
        w_anim_frame_d = ~r_anim_frame;
      end else begin
        w_anim_cnt_d = r_anim_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_line_y     <= '0;
      r_acc        <= '0;
      r_mask       <= '0;
      r_mask_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_anim_cnt   <= '0;
      r_anim_frame <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_idx        <= w_idx_d;
      r_line_y     <= w_line_y_d;
      r_acc        <= w_acc_d;
      r_mask       <= w_mask_d;
      r_mask_valid <= w_mask_valid_d;
      r_overrun    <= w_overrun_d;
      r_anim_cnt   <= w_anim_cnt_d;
      r_anim_frame <= w_anim_frame_d;
    end
  end

  // Out-of-range slot ids match no entry, so they are accepted and dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_stg_x[i]   <= '0;
        r_stg_y[i]   <= '0;
        r_stg_dir[i] <= DIR_UP;
        r_shd_x[i]   <= '0;
        r_shd_y[i]   <= '0;
        r_shd_dir[i] <= DIR_UP;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (w_accept && (upd_if.upd_id == 3'(i))) begin
          r_stg_x[i]   <= upd_if.upd_x;
          r_stg_y[i]   <= upd_if.upd_y;
          r_stg_dir[i] <= upd_if.upd_dir;
        end
        if (w_commit) begin
          r_shd_x[i]   <= r_stg_x[i];
          r_shd_y[i]   <= r_stg_y[i];
          r_shd_dir[i] <= r_stg_dir[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pack
    assign o_spr_x[g*X_W +: X_W] = r_shd_x[g];
    assign o_spr_y[g*Y_W +: Y_W] = r_shd_y[g];
    assign o_spr_dir[g*2 +: 2]   = r_shd_dir[g];
  end

  assign o_anim_frame      = r_anim_frame;
  assign o_line_mask       = r_mask;
  assign o_line_mask_valid = r_mask_valid;
  assign o_overrun         = r_overrun;

endmodule

// File: tb/tb_render_frame_sequencer.sv
// Directed bench for render_frame_sequencer: reset, commit, scan masks, overrun, animation timer.
module tb_render_frame_sequencer;
  import render_frame_sequencer_pkg::*;

  localparam int unsigned NS = 5;
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      r_game_state;
  logic            r_frame_start;
  logic            r_line_start;
  logic [YW-1:0]   r_line_y;
  logic [NS*XW-1:0] w_spr_x;
  logic [NS*YW-1:0] w_spr_y;
  logic [NS*2-1:0]  w_spr_dir;
  logic            w_anim_frame;
  logic [NS-1:0]   w_line_mask;
  logic            w_line_mask_valid;
  logic            w_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XW-1:0] m_stg_x [NS];
  logic [YW-1:0] m_stg_y [NS];
  logic [1:0]    m_stg_dir [NS];
  logic [XW-1:0] m_shd_x [NS];
  logic [YW-1:0] m_shd_y [NS];
  logic [1:0]    m_shd_dir [NS];

  render_frame_sequencer_if #(.X_W(XW), .Y_W(YW)) upd_if ();

  render_frame_sequencer #(
    .NUM_SPRITES (NS),
    .X_W         (XW),
    .Y_W         (YW),
    .TILE_SIZE   (20),
    .ANIM_DIV    (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_game_state      (r_game_state),
    .i_frame_start     (r_frame_start),
    .i_line_start      (r_line_start),
    .i_line_y          (r_line_y),
    .upd_if            (upd_if),
    .o_spr_x           (w_spr_x),
    .o_spr_y           (w_spr_y),
    .o_spr_dir         (w_spr_dir),
    .o_anim_frame      (w_anim_frame),
    .o_line_mask       (w_line_mask),
    .o_line_mask_valid (w_line_mask_valid),
    .o_overrun         (w_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_shadow(input string tag);
    logic [63:0] ex, ey, ed;
    ex = '0; ey = '0; ed = '0;
    for (int i = 0; i < NS; i++) begin
      ex[i*XW +: XW] = m_shd_x[i];
      ey[i*YW +: YW] = m_shd_y[i];
      ed[i*2 +: 2]   = m_shd_dir[i];
    end
    chk({tag, "_x"}, 64'(w_spr_x), ex);
    chk({tag, "_y"}, 64'(w_spr_y), ey);
    chk({tag, "_dir"}, 64'(w_spr_dir), ed);
  endtask

  task automatic send_upd(input int id, input int x, input int y, input int dir);
    upd_if.upd_valid = 1'b1;
    upd_if.upd_id    = 3'(id);
    upd_if.upd_x     = XW'(x);
    upd_if.upd_y     = YW'(y);
    upd_if.upd_dir   = 2'(dir);
    chk("upd_ready_idle", 64'(upd_if.upd_ready), 64'd1);
    tick();
    upd_if.upd_valid = 1'b0;
    if (id < NS) begin
      m_stg_x[id]   = XW'(x);
      m_stg_y[id]   = YW'(y);
      m_stg_dir[id] = 2'(dir);
    end
  endtask

  task automatic commit_model();
    for (int i = 0; i < NS; i++) begin
      m_shd_x[i]   = m_stg_x[i];
      m_shd_y[i]   = m_stg_y[i];
      m_shd_dir[i] = m_stg_dir[i];
    end
  endtask

  task automatic do_frame(input string tag);
    r_frame_start = 1'b1;
    tick();
    r_frame_start = 1'b0;
    chk({tag, "_ready_commit"}, 64'(upd_if.upd_ready), 64'd0);
    commit_model();
    tick();
    chk_shadow(tag);
  endtask

  // Valid must be low for cycles 1..5 after line_start, high at 6, low again at 7.
  task automatic run_line(input int y, input logic [NS-1:0] exp, input string tag);
    r_line_y     = YW'(y);
    r_line_start = 1'b1;
    tick();
    r_line_start = 1'b0;
    for (int k = 1; k < 6; k++) begin
      chk({tag, "_early_valid"}, 64'(w_line_mask_valid), 64'd0);
      tick();
    end
    chk({tag, "_valid"}, 64'(w_line_mask_valid), 64'd1);
    chk({tag, "_mask"}, 64'(w_line_mask), 64'(exp));
    tick();
    chk({tag, "_valid_drop"}, 64'(w_line_mask_valid), 64'd0);
    chk({tag, "_mask_hold"}, 64'(w_line_mask), 64'(exp));
  endtask

  initial begin
    int pf;
    rst              = 1'b1;
    r_game_state     = 3'd0;
    r_frame_start    = 1'b0;
    r_line_start     = 1'b0;
    r_line_y         = '0;
    upd_if.upd_valid = 1'b0;
    upd_if.upd_id    = '0;
    upd_if.upd_x     = '0;
    upd_if.upd_y     = '0;
    upd_if.upd_dir   = '0;
    for (int i = 0; i < NS; i++) begin
      m_stg_x[i] = '0; m_stg_y[i] = '0; m_stg_dir[i] = '0;
    end
    commit_model();

    tick();
    tick();
    chk("rst_mask", 64'(w_line_mask), 64'd0);
    chk("rst_valid", 64'(w_line_mask_valid), 64'd0);
    chk("rst_overrun", 64'(w_overrun), 64'd0);
    chk("rst_anim", 64'(w_anim_frame), 64'd0);
    chk("rst_ready", 64'(upd_if.upd_ready), 64'd1);
    chk_shadow("rst");
    rst = 1'b0;
    tick();

    run_line(0, 5'b11111, "line0");

    // Overrun, then asynchronous reset in the middle of the restarted scan.
    r_line_y     = '0;
    r_line_start = 1'b1;
    tick();
    r_line_start = 1'b0;
    tick();
    r_line_start = 1'b1;
    tick();
    r_line_start = 1'b0;
    chk("pre_rst_overrun", 64'(w_overrun), 64'd1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midscan_rst_mask", 64'(w_line_mask), 64'd0);
    chk("midscan_rst_overrun", 64'(w_overrun), 64'd0);
    chk("midscan_rst_valid", 64'(w_line_mask_valid), 64'd0);
    chk("midscan_rst_ready", 64'(upd_if.upd_ready), 64'd1);
    #1 rst = 1'b0;
    tick();
    run_line(0, 5'b11111, "post_rst");

    // Staged update is invisible until committed.
    send_upd(2, 100, 40, 3);
    tick();
    chk_shadow("staged_only");
    chk("staged_only_x2", 64'(w_spr_x[2*XW +: XW]), 64'd0);
    do_frame("commit_s2");
    chk("commit_x2", 64'(w_spr_x[2*XW +: XW]), 64'd100);
    chk("commit_y2", 64'(w_spr_y[2*YW +: YW]), 64'd40);
    chk("commit_dir2", 64'(w_spr_dir[4 +: 2]), 64'd3);
    send_upd(2, 200, 41, 1);
    tick();
    tick();
    chk("nocommit_x2", 64'(w_spr_x[2*XW +: XW]), 64'd100);
    send_upd(2, 100, 40, 3);

    send_upd(1, 7, 50, 1);
    do_frame("commit_s1");

    run_line(69, 5'b00010, "y69");
    run_line(70, 5'b00000, "y70");
    run_line(49, 5'b00100, "y49");
    run_line(55, 5'b00110, "y55");
    run_line(19, 5'b11001, "y19");

    // Second line_start at scan cycle 3 aborts the first line.
    r_line_y     = YW'(69);
    r_line_start = 1'b1;
    tick();
    r_line_start = 1'b0;
    tick();
    tick();
    chk("overrun_before", 64'(w_overrun), 64'd0);
    run_line(55, 5'b00110, "overrun_line");
    chk("overrun_sticky", 64'(w_overrun), 64'd1);

    // frame_start and line_start together: commit, no scan.
    r_line_y      = YW'(19);
    r_frame_start = 1'b1;
    r_line_start  = 1'b1;
    tick();
    r_frame_start = 1'b0;
    r_line_start  = 1'b0;
    chk("fs_ls_ready", 64'(upd_if.upd_ready), 64'd0);
    commit_model();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("fs_ls_novalid", 64'(w_line_mask_valid), 64'd0);
    end
    chk("fs_ls_mask_hold", 64'(w_line_mask), 64'b00110);
    chk("fs_ls_overrun", 64'(w_overrun), 64'd1);

    // Update presented during COMMIT waits one cycle.
    r_frame_start = 1'b1;
    tick();
    r_frame_start    = 1'b0;
    upd_if.upd_valid = 1'b1;
    upd_if.upd_id    = 3'd3;
    upd_if.upd_x     = XW'(33);
    upd_if.upd_y     = YW'(60);
    upd_if.upd_dir   = 2'd2;
    chk("commit_upd_ready", 64'(upd_if.upd_ready), 64'd0);
    commit_model();
    tick();
    chk("after_commit_ready", 64'(upd_if.upd_ready), 64'd1);
    tick();
    upd_if.upd_valid = 1'b0;
    m_stg_x[3] = XW'(33); m_stg_y[3] = YW'(60); m_stg_dir[3] = 2'd2;
    chk_shadow("commit_upd_pending");
    do_frame("commit_s3");
    chk("commit_y3", 64'(w_spr_y[3*YW +: YW]), 64'd60);
    run_line(65, 5'b01010, "y65");

    // Out-of-range slot is dropped.
    send_upd(6, 999, 999, 3);
    do_frame("slot6");

    // Animation: toggles every 8 playing frames; non-playing frames hold the counter.
    pf = 0;
    for (int f = 0; f < 21; f++) begin
      logic playing;
      playing      = !(f >= 3 && f < 8);
      r_game_state = playing ? GAME_STATE_PLAYING : 3'd2;
      do_frame("anim");
      if (playing) pf++;
      chk($sformatf("anim_f%0d", f), 64'(w_anim_frame), 64'((pf / 8) % 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
